// File: rtl/sync_filter_nbit.sv
// Multi-channel level synchroniser with a per-channel stability filter and
// registered rise/fall/change pulses derived from the filtered level.
module sync_filter_nbit #(
    parameter int              WIDTH         = 1,
    parameter int              STAGES        = 2,
    parameter int              FILTER_CYCLES = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] out_rise,
    output logic [WIDTH-1:0] out_fall,
    output logic             out_change
);
    localparam int CNT_W = $clog2(FILTER_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

    if (STAGES < 2) begin : g_bad_stages
        $error("sync_filter_nbit: STAGES must be >= 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
        $error("sync_filter_nbit: FILTER_CYCLES must be >= 1");
    end

    (* async_reg = "true" *) logic [WIDTH-1:0] sync_q [STAGES];
    logic [WIDTH-1:0] sync_d [STAGES];
    logic [WIDTH-1:0] sync_s;

    logic [CNT_W-1:0] cnt_q [WIDTH];
    logic [CNT_W-1:0] cnt_d [WIDTH];
    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic             change_q, change_d;

    always_comb begin
        sync_d[0] = in_data;
        for (int i = 1; i < STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    assign sync_s = sync_q[STAGES-1];

    // A differing level must be seen on FILTER_CYCLES consecutive edges; any
    // return to the accepted level clears the partial count.
    always_comb begin
        data_d = data_q;
        rise_d = '0;
        fall_d = '0;
        for (int ch = 0; ch < WIDTH; ch++) begin
            cnt_d[ch] = cnt_q[ch];
            if (sync_s[ch] == data_q[ch]) begin
                cnt_d[ch] = '0;
            end else if (cnt_q[ch] == CNT_LAST) begin
                data_d[ch] = sync_s[ch];
                cnt_d[ch]  = '0;
                rise_d[ch] = sync_s[ch];
                fall_d[ch] = ~sync_s[ch];
            end else begin
                cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
            end
        end
        change_d = |{rise_d, fall_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= RESET_VALUE;
            end
            for (int ch = 0; ch < WIDTH; ch++) begin
                cnt_q[ch] <= '0;
            end
            data_q   <= RESET_VALUE;
            rise_q   <= '0;
            fall_q   <= '0;
            change_q <= 1'b0;
        end else begin
            for (int i = 0; i < STAGES; i++) begin
                sync_q[i] <= sync_d[i];
            end
            for (int ch = 0; ch < WIDTH; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
            data_q   <= data_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            change_q <= change_d;
        end
    end

    assign out_data   = data_q;
    assign out_rise   = rise_q;
    assign out_fall   = fall_q;
    assign out_change = change_q;

endmodule
